shift_cmd_queue: RTL and testbench

Buffered issue stage in front of the existing combinational `shifter` datapath. Accepts shift commands (operand, amount, type) over a valid/ready handshake and queues them in a DEPTH-entry FIFO. It applies the head entry to a `shifter` instance and presents each result through a registered valid/ready output. This decouples bursty producers from the consumer and sustains one shift per cycle.

---
 rtl/shift_pkg.sv | 12 +
 rtl/shifter.sv | 19 +
 rtl/shift_cmd_queue.sv | 63 ++++++
 tb/tb_shift_cmd_queue.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// shift_pkg: shift type codes and the queued command record
package shift_pkg;
  localparam logic [1:0] SH_LEFT = 2'b00;
  localparam logic [1:0] SH_LSR  = 2'b01;
  localparam logic [1:0] SH_ASR  = 2'b10;
  localparam logic [1:0] SH_RSVD = 2'b11;
  typedef struct packed {
    logic [7:0] data;
    logic [3:0] shamt;
    logic [1:0] shtype;
  } shift_cmd_t;
endpackage

// File: rtl/shifter.sv
// shifter: combinational 8-bit shifter, amounts 8-15 shift everything out
module shifter
  import shift_pkg::*;
(
  input  logic [7:0] data,
  input  logic [3:0] shamt,
  input  logic [1:0] shtype,
  output logic [7:0] result,
  output logic       err
);
  logic [7:0] asr;
  assign asr = $signed(data) >>> shamt;
  always_comb begin
    result = shtype == SH_LEFT ? data << shamt :
             shtype == SH_LSR  ? data >> shamt :
             shtype == SH_ASR  ? asr : 8'h00;
    err = shtype == SH_RSVD;
  end
endmodule

// File: rtl/shift_cmd_queue.sv
// shift_cmd_queue: FIFO of shift commands feeding a shifter into a registered valid/ready output
module shift_cmd_queue
  import shift_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 in_data,
  input  logic [3:0]                 in_shamt,
  input  logic [1:0]                 in_shtype,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 out_data,
  output logic                       out_err,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  shift_cmd_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic push, load, empty, err;
  logic [7:0] result;
  shift_cmd_t head;
  assign empty    = count == '0;
  assign in_ready = rst_n && count != CW'(DEPTH);
  assign push     = in_valid && in_ready;
  assign load     = !empty && (!out_valid || out_ready);
  assign head     = mem[rp];
  shifter u_shifter (
    .data   (head.data),
    .shamt  (head.shamt),
    .shtype (head.shtype),
    .result (result),
    .err    (err)
  );
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= '{data: in_data, shamt: in_shamt, shtype: in_shtype};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_err   <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (load) begin
        rp        <= rp + 1'b1;
        out_data  <= result;
        out_err   <= err;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      count <= count + CW'(push) - CW'(load);
    end
  end
endmodule

// File: tb/tb_shift_cmd_queue.sv
// tb_shift_cmd_queue: directed vector table plus stall, stream and reset sequences
module tb_shift_cmd_queue;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, out_err;
  logic [7:0] in_data = 8'h00, out_data;
  logic [3:0] in_shamt = 4'd0;
  logic [1:0] in_shtype = 2'b00;
  logic [2:0] count;
  int checks = 0, errors = 0;
  typedef struct {
    logic [7:0] d;
    logic [3:0] a;
    logic [1:0] t;
    logic [7:0] ed;
    logic       ee;
  } vec_t;
  vec_t vecs [7];
  logic [13:0] cmds [16];
  always #5 clk = ~clk;
  shift_cmd_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shamt(in_shamt), .in_shtype(in_shtype),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .count(count)
  );
  function automatic logic [7:0] model(logic [7:0] d, logic [3:0] a, logic [1:0] t);
    logic [7:0] r = d;
    if (t == 2'b11) return 8'h00;
    for (int i = 0; i < a; i++)
      r = t == 2'b00 ? {r[6:0], 1'b0} : t == 2'b01 ? {1'b0, r[7:1]} : {r[7], r[7:1]};
    return r;
  endfunction
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(logic [7:0] d, logic [3:0] a, logic [1:0] t);
    in_valid = 1'b1; in_data = d; in_shamt = a; in_shtype = t;
  endtask
  initial begin
    logic [7:0] exp_q [$];
    int got, first, last;
    vecs[0] = '{8'h81, 4'd3, 2'b10, 8'hF0, 1'b0};
    vecs[1] = '{8'h80, 4'd15, 2'b10, 8'hFF, 1'b0};
    vecs[2] = '{8'h7F, 4'd8, 2'b10, 8'h00, 1'b0};
    vecs[3] = '{8'hFF, 4'd8, 2'b00, 8'h00, 1'b0};
    vecs[4] = '{8'hA5, 4'd0, 2'b01, 8'hA5, 1'b0};
    vecs[5] = '{8'h55, 4'd2, 2'b11, 8'h00, 1'b1};
    vecs[6] = '{8'h3C, 4'd2, 2'b00, 8'hF0, 1'b0};
    tick(); tick();
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1 chk("in_ready_after_rst", in_ready, 1);
    foreach (vecs[i]) begin
      drive(vecs[i].d, vecs[i].a, vecs[i].t);
      tick();
      in_valid = 1'b0;
      chk("vec_count_after_push", count, 1);
      chk("vec_valid_latency", out_valid, 0);
      tick();
      chk("vec_valid", out_valid, 1);
      chk($sformatf("vec%0d_data", i), out_data, vecs[i].ed);
      chk($sformatf("vec%0d_err", i), out_err, vecs[i].ee);
      tick();
      chk("vec_valid_clear", out_valid, 0);
    end
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(8'h11 * (i + 1), 4'(i), 2'b00);
      exp_q.push_back(model(8'h11 * (i + 1), 4'(i), 2'b00));
      tick();
    end
    in_valid = 1'b0;
    chk("stall_in_ready", in_ready, 0);
    chk("stall_count", count, 4);
    chk("stall_out_valid", out_valid, 1);
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) begin
        if (got < 5) chk($sformatf("drain%0d", got), out_data, exp_q[got]);
        got++;
      end
      tick();
    end
    chk("drain_total", got, 5);
    exp_q.delete();
    foreach (cmds[i]) begin
      cmds[i] = 14'($urandom);
      exp_q.push_back(model(cmds[i][13:6], cmds[i][5:2], cmds[i][1:0]));
    end
    got = 0; first = -1; last = -1;
    drive(cmds[0][13:6], cmds[0][5:2], cmds[0][1:0]);
    for (int c = 0; c < 40; c++) begin
      tick();
      if (out_valid) begin
        if (got < 16) chk($sformatf("stream%0d", got), out_data, exp_q[got]);
        if (first < 0) first = c;
        last = c;
        got++;
      end
      if (c + 1 < 16) drive(cmds[c+1][13:6], cmds[c+1][5:2], cmds[c+1][1:0]);
      else in_valid = 1'b0;
      if (c >= 2 && c < 15) chk("stream_count", count, 1);
    end
    chk("stream_total", got, 16);
    chk("stream_span", last - first, 15);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(8'hC0 | 8'(i), 4'd1, 2'b01);
      tick();
    end
    in_valid = 1'b0;
    chk("pre_rst_count", count, 3);
    chk("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_valid", out_valid, 0);
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (out_valid) got++;
    end
    chk("no_stale_results", got, 0);
    drive(8'h0F, 4'd4, 2'b00);
    tick();
    in_valid = 1'b0;
    tick();
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_data", out_data, 8'hF0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
